// File: rtl/s_term_ram_io_pkg.sv
// Shared types and sizing helpers for the south-edge RAM_IO terminal bridge.
package s_term_ram_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 15;

  // Wide enough to hold every value 0..timeout.
  function automatic int cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/s_term_ram_io_bridge_req_edge.sv
// Registers the fabric request wire and produces a one-cycle rising-edge pulse.
module ram_io_req_edge (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic req_edge
);

  logic req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= 1'b0;
    else     req_q <= req;
  end

  assign req_edge = req & ~req_q;

endmodule

// File: rtl/s_term_ram_io_bridge.sv
// Fabric-to-RAM-macro bridge: edge-triggered request, held req/ack handshake,
// ack timeout, and registered read data / done / error / overrun status.
module s_term_ram_io_bridge
  import s_term_ram_io_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              UserCLK,
  input  logic              reset,
  input  logic              fab_req,
  input  logic              fab_we,
  input  logic [ADDR_W-1:0] fab_addr,
  input  logic [DATA_W-1:0] fab_wdata,
  output logic [DATA_W-1:0] fab_rdata,
  output logic              fab_busy,
  output logic              fab_done,
  output logic              fab_err,
  output logic              fab_ovf,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int               CNT_W    = cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             req_edge;

  ram_io_req_edge u_req_edge (
    .clk      (UserCLK),
    .rst      (reset),
    .req      (fab_req),
    .req_edge (req_edge)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_edge) state_nxt = REQ;
      REQ:     if (mem_ack || (cnt == CNT_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Done is exactly the single DONE-state cycle, so it drops with async reset.
  assign fab_done = (state == DONE);

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fab_rdata <= '0;
      fab_busy  <= 1'b0;
      fab_err   <= 1'b0;
      fab_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (req_edge) begin
            mem_we    <= fab_we;
            mem_addr  <= fab_addr;
            mem_wdata <= fab_wdata;
            mem_req   <= 1'b1;
            fab_busy  <= 1'b1;
            fab_err   <= 1'b0;
            fab_ovf   <= 1'b0;
            cnt       <= '0;
          end
        end
        REQ: begin
          if (req_edge) fab_ovf <= 1'b1;
          cnt <= cnt + CNT_W'(1);
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            if (!mem_we) fab_rdata <= mem_rdata;
            mem_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            mem_req <= 1'b0;
            fab_err <= 1'b1;
          end
        end
        DONE: begin
          if (req_edge) fab_ovf <= 1'b1;
          cnt      <= '0;
          fab_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_s_term_ram_io_bridge.sv
// Scoreboard bench for s_term_ram_io_bridge: expected outcomes are queued as
// requests are issued and checked when fab_done pulses.
module tb_s_term_ram_io_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    logic             we;
    logic [7:0]       addr;
    logic [7:0]       wdata;
    logic [7:0]       rdata;
    logic             err;
    int               len;
  } sb_item_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fab_req = 1'b0;
  logic              fab_we = 1'b0;
  logic [ADDR_W-1:0] fab_addr = '0;
  logic [DATA_W-1:0] fab_wdata = '0;
  logic [DATA_W-1:0] fab_rdata;
  logic              fab_busy, fab_done, fab_err, fab_ovf;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;

  sb_item_t   sb[$];
  int         errors = 0;
  int         checks = 0;
  int         done_cnt = 0;
  int         req_rises = 0;
  int         cyc = 0;
  int         ack_at = 0;
  logic       idle_ack = 1'b0;
  logic [7:0] rd_val = '0;
  logic [7:0] rdata_model = '0;
  logic       prev_req = 1'b0;
  logic       prev_done = 1'b0;

  s_term_ram_io_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .UserCLK  (clk),
    .reset    (reset),
    .fab_req  (fab_req),
    .fab_we   (fab_we),
    .fab_addr (fab_addr),
    .fab_wdata(fab_wdata),
    .fab_rdata(fab_rdata),
    .fab_busy (fab_busy),
    .fab_done (fab_done),
    .fab_err  (fab_err),
    .fab_ovf  (fab_ovf),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM responder and scoreboard checker, both evaluated mid-cycle.
  always @(negedge clk) begin
    sb_item_t e;
    if (reset) begin
      cyc = 0;
      prev_req = 1'b0;
      prev_done = 1'b0;
      mem_ack = 1'b0;
    end else begin
      if (fab_done) begin
        done_cnt++;
        chk("done_after_req", {31'd0, prev_req}, 32'd1);
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("err", {31'd0, fab_err}, {31'd0, e.err});
          chk("rdata", {24'd0, fab_rdata}, {24'd0, e.rdata});
          chk("req_len", cyc, e.len);
        end
      end
      if (prev_done) chk("done_width", {31'd0, fab_done}, 32'd0);
      if (mem_req) begin
        if (!prev_req) begin
          req_rises++;
          if (sb.size() > 0) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
            chk("mem_addr", {24'd0, mem_addr}, {24'd0, sb[0].addr});
            if (sb[0].we) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, sb[0].wdata});
          end
        end
        cyc++;
      end else begin
        cyc = 0;
      end
      mem_ack   = (mem_req && (cyc == ack_at)) || idle_ack;
      mem_rdata = rd_val;
      prev_req  = mem_req;
      prev_done = fab_done;
    end
  end

  task automatic push_exp(input logic we, input logic [7:0] a, input logic [7:0] wd,
                          input int ack, input logic [7:0] rd);
    sb_item_t e;
    logic ok;
    ok = (ack > 0) && (ack <= TIMEOUT);
    ack_at = ack;
    rd_val = rd;
    if (ok && !we) rdata_model = rd;
    e.we = we; e.addr = a; e.wdata = wd;
    e.err = !ok;
    e.len = ok ? ack : TIMEOUT;
    e.rdata = rdata_model;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 40 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("busy_after", {31'd0, fab_busy}, 32'd0);
  endtask

  task automatic do_txn(input logic we, input logic [7:0] a, input logic [7:0] wd,
                        input int ack, input logic [7:0] rd);
    int d0;
    push_exp(we, a, wd, ack, rd);
    d0 = done_cnt;
    @(posedge clk); #1;
    fab_req = 1'b1; fab_we = we; fab_addr = a; fab_wdata = wd;
    @(negedge clk);
    chk("req_lat0", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    fab_req = 1'b0; fab_we = 1'b0; fab_addr = '0; fab_wdata = '0;
    @(negedge clk);
    chk("req_lat1", {31'd0, mem_req}, 32'd1);
    chk("busy", {31'd0, fab_busy}, 32'd1);
    chk("err_clr", {31'd0, fab_err}, 32'd0);
    chk("ovf_clr", {31'd0, fab_ovf}, 32'd0);
    wait_done(d0);
  endtask

  initial begin
    int d0, r0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_outs", {fab_busy, fab_done, fab_err, fab_ovf, mem_we, mem_addr, mem_wdata, fab_rdata},
        32'd0);
    @(posedge clk); #3;
    reset = 1'b0;

    do_txn(1'b1, 8'h10, 8'h5A, 1, 8'h00);
    do_txn(1'b0, 8'h3C, 8'h00, 2, 8'hA5);
    do_txn(1'b0, 8'h55, 8'h00, 0, 8'hEE);
    chk("err_sticky", {31'd0, fab_err}, 32'd1);
    do_txn(1'b0, 8'h66, 8'h00, TIMEOUT, 8'h3D);

    // Acks arriving while idle must be ignored.
    d0 = done_cnt;
    rd_val = 8'h77;
    idle_ack = 1'b1;
    repeat (3) @(posedge clk);
    idle_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_rdata", {24'd0, fab_rdata}, {24'd0, rdata_model});
    chk("idle_ack_busy", {31'd0, fab_busy}, 32'd0);
    chk("idle_ack_done", done_cnt - d0, 32'd0);

    // Level held high plus a second edge during REQ: one transaction, overrun flagged.
    d0 = done_cnt;
    r0 = req_rises;
    push_exp(1'b0, 8'h21, 8'h00, 8, 8'hC3);
    @(posedge clk); #1;
    fab_req = 1'b1; fab_we = 1'b0; fab_addr = 8'h21;
    repeat (3) @(posedge clk);
    #1 fab_req = 1'b0;
    @(posedge clk); #1 fab_req = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("ovf_set", {31'd0, fab_ovf}, 32'd1);
    chk("one_txn", req_rises - r0, 32'd1);
    chk("one_done", done_cnt - d0, 32'd1);
    @(posedge clk); #1 fab_req = 1'b0;
    @(negedge clk);
    chk("ovf_sticky", {31'd0, fab_ovf}, 32'd1);
    do_txn(1'b1, 8'h7F, 8'h99, 3, 8'h00);

    // Asynchronous reset in the middle of REQ.
    push_exp(1'b0, 8'h44, 8'h00, 0, 8'h00);
    @(posedge clk); #1;
    fab_req = 1'b1; fab_addr = 8'h44;
    @(posedge clk); #1;
    fab_req = 1'b0; fab_addr = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_req", {31'd0, mem_req}, 32'd1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, mem_req}, 32'd0);
    chk("arst_busy", {31'd0, fab_busy}, 32'd0);
    chk("arst_outs", {fab_done, fab_err, fab_ovf, mem_we, mem_addr, mem_wdata, fab_rdata}, 32'd0);
    sb.delete();
    rdata_model = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (2) @(posedge clk);
    chk("no_done_rst", done_cnt - d0, 32'd0);
    do_txn(1'b0, 8'h12, 8'h00, 4, 8'hB7);

    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
